// File: rtl/mesh_edge_endpoint.sv
// Off-mesh endpoint for one boundary port of the neuron_cell mesh: flit TX serialiser plus RX flit FIFO and packet reassembly.
// Optional statistics counters are built when MESH_EDGE_STATS_EN is defined.
module mesh_edge_endpoint #(
  parameter int PKT_FLITS = 2,
  parameter int RX_DEPTH  = 4
`ifdef MESH_EDGE_STATS_EN
  ,
  parameter int CNT_W     = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [3:0]             to_mesh,
  output logic                   to_mesh_en,
  input  logic                   mesh_full,
  input  logic [3:0]             from_mesh,
  input  logic                   from_mesh_w,
  output logic                   mesh_n_full,
  input  logic [4*PKT_FLITS-1:0] tx_pkt,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [4*PKT_FLITS-1:0] rx_pkt,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   rx_ovf
`ifdef MESH_EDGE_STATS_EN
  ,
  output logic [CNT_W-1:0]       tx_pkt_cnt,
  output logic [CNT_W-1:0]       rx_pkt_cnt,
  output logic [CNT_W-1:0]       ovf_cnt
`endif
);

  localparam int PW     = 4 * PKT_FLITS;
  localparam int AW     = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int IW     = $clog2(PKT_FLITS);
  localparam int ONE_I  = 1;
  localparam int LAST_I = PKT_FLITS - 1;
  localparam int NF_I   = RX_DEPTH - 1;

  localparam logic [IW-1:0] IDX_LAST = LAST_I[IW-1:0];
  localparam logic [IW-1:0] IDX_ONE  = ONE_I[IW-1:0];
  localparam logic [AW-1:0] PTR_ONE  = ONE_I[AW-1:0];
  localparam logic [AW:0]   OCC_ONE  = ONE_I[AW:0];
  localparam logic [AW:0]   OCC_FULL = RX_DEPTH[AW:0];
  localparam logic [AW:0]   OCC_NF   = NF_I[AW:0];

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          send_s;

  logic [3:0]    mem_q [RX_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [PW-5:0] asm_q, asm_d;
  logic [PW-1:0] asm_ext_s;
  logic [IW-1:0] acnt_q, acnt_d;
  logic [PW-1:0] rx_pkt_q, rx_pkt_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ovf_q, rx_ovf_d;
  logic          n_full_q, n_full_d;
  logic          fifo_full_s, push_s, drop_s, pop_s, complete_s;
  logic [3:0]    head_s;

  // TX serialiser: latch a packet in IDLE, emit one nibble per cycle the cell can take it
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    send_s  = (state_q == ST_SEND) && !mesh_full;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d = ST_SEND;
          shift_d = tx_pkt;
          idx_d   = {IW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!mesh_full) begin
          shift_d = {shift_q[PW-5:0], 4'h0};
          idx_d   = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign to_mesh    = (state_q == ST_SEND) ? shift_q[PW-1 -: 4] : 4'h0;
  assign to_mesh_en = send_s;
  assign tx_ready   = (state_q == ST_IDLE);

  assign head_s    = mem_q[rd_ptr_q];
  assign asm_ext_s = {asm_q, head_s};

  // RX FIFO bookkeeping; a completing pop is held off while the host still owns rx_pkt
  always_comb begin
    fifo_full_s = (occ_q == OCC_FULL);
    push_s      = from_mesh_w && !fifo_full_s;
    drop_s      = from_mesh_w && fifo_full_s;
    if (occ_q != {(AW+1){1'b0}}) begin
      pop_s = !((acnt_q == IDX_LAST) && rx_valid_q && !rx_ready);
    end else begin
      pop_s = 1'b0;
    end
    complete_s = pop_s && (acnt_q == IDX_LAST);

    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
    // One slot of slack covers the flit the cell already launched before seeing n_full.
    n_full_d = (occ_d >= OCC_NF);
    rx_ovf_d = rx_ovf_q | drop_s;

    asm_d      = asm_q;
    acnt_d     = acnt_q;
    rx_pkt_d   = rx_pkt_q;
    rx_valid_d = rx_valid_q;
    if (complete_s) begin
      rx_pkt_d   = asm_ext_s;
      acnt_d     = {IW{1'b0}};
      rx_valid_d = 1'b1;
    end else if (pop_s) begin
      asm_d  = asm_ext_s[PW-5:0];
      acnt_d = acnt_q + IDX_ONE;
      if (rx_valid_q && rx_ready) begin
        rx_valid_d = 1'b0;
      end else begin
        rx_valid_d = rx_valid_q;
      end
    end else begin
      if (rx_valid_q && rx_ready) begin
        rx_valid_d = 1'b0;
      end else begin
        rx_valid_d = rx_valid_q;
      end
    end
  end

  // FIFO storage needs no reset: occupancy guards every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= from_mesh;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= {PW{1'b0}};
      idx_q      <= {IW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      occ_q      <= {(AW+1){1'b0}};
      asm_q      <= {(PW-4){1'b0}};
      acnt_q     <= {IW{1'b0}};
      rx_pkt_q   <= {PW{1'b0}};
      rx_valid_q <= 1'b0;
      rx_ovf_q   <= 1'b0;
      n_full_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      asm_q      <= asm_d;
      acnt_q     <= acnt_d;
      rx_pkt_q   <= rx_pkt_d;
      rx_valid_q <= rx_valid_d;
      rx_ovf_q   <= rx_ovf_d;
      n_full_q   <= n_full_d;
    end
  end

  assign rx_pkt      = rx_pkt_q;
  assign rx_valid    = rx_valid_q;
  assign rx_ovf      = rx_ovf_q;
  assign mesh_n_full = n_full_q;

`ifdef MESH_EDGE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = ONE_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             tx_done_s;

  assign tx_done_s = send_s && (idx_q == IDX_LAST);

  // Saturating event counters
  always_comb begin
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (tx_done_s && (tx_cnt_q != CNT_MAX)) begin
      tx_cnt_d = tx_cnt_q + CNT_ONE;
    end else begin
      tx_cnt_d = tx_cnt_q;
    end
    if (complete_s && (rx_cnt_q != CNT_MAX)) begin
      rx_cnt_d = rx_cnt_q + CNT_ONE;
    end else begin
      rx_cnt_d = rx_cnt_q;
    end
    if (drop_s && (ovf_cnt_q != CNT_MAX)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_ONE;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_cnt_q  <= {CNT_W{1'b0}};
      rx_cnt_q  <= {CNT_W{1'b0}};
      ovf_cnt_q <= {CNT_W{1'b0}};
    end else begin
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign tx_pkt_cnt = tx_cnt_q;
  assign rx_pkt_cnt = rx_cnt_q;
  assign ovf_cnt    = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_mesh_edge_endpoint.sv
// Self-checking bench for mesh_edge_endpoint: queue-based reference model compared every cycle, plus pinned literal checks.
module tb_mesh_edge_endpoint;

  localparam int PKT_FLITS = 2;
  localparam int RX_DEPTH  = 4;
  localparam int PW        = 4 * PKT_FLITS;
`ifdef MESH_EDGE_STATS_EN
  localparam int CNT_W     = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    to_mesh;
  logic          to_mesh_en;
  logic          mesh_full;
  logic [3:0]    from_mesh;
  logic          from_mesh_w;
  logic          mesh_n_full;
  logic [PW-1:0] tx_pkt;
  logic          tx_valid;
  logic          tx_ready;
  logic [PW-1:0] rx_pkt;
  logic          rx_valid;
  logic          rx_ready;
  logic          rx_ovf;
`ifdef MESH_EDGE_STATS_EN
  logic [CNT_W-1:0] tx_pkt_cnt, rx_pkt_cnt, ovf_cnt;
`endif

  always #5 clk = ~clk;

  mesh_edge_endpoint #(
    .PKT_FLITS (PKT_FLITS),
    .RX_DEPTH  (RX_DEPTH)
`ifdef MESH_EDGE_STATS_EN
    ,
    .CNT_W     (CNT_W)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .to_mesh     (to_mesh),
    .to_mesh_en  (to_mesh_en),
    .mesh_full   (mesh_full),
    .from_mesh   (from_mesh),
    .from_mesh_w (from_mesh_w),
    .mesh_n_full (mesh_n_full),
    .tx_pkt      (tx_pkt),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_pkt      (rx_pkt),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_ovf      (rx_ovf)
`ifdef MESH_EDGE_STATS_EN
    ,
    .tx_pkt_cnt  (tx_pkt_cnt),
    .rx_pkt_cnt  (rx_pkt_cnt),
    .ovf_cnt     (ovf_cnt)
`endif
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: TX as a queue of pending nibbles, RX as a flit queue plus list of collected flits
  bit         m_on = 1'b0;
  bit         m_tx_busy;
  logic [3:0] m_txq [$];
  logic [3:0] m_fifo [$];
  logic [3:0] m_asm [$];
  bit         m_rxv;
  logic [PW-1:0] m_pkt;
  bit         m_ovf;
  bit         m_nfull;
  int         m_txc, m_rxc, m_ovc;

  always @(posedge clk) begin : model
    bit was_full;
    bit do_pop;
    bit done;
    logic [3:0] f;
    logic [PW-1:0] p;
    if (!rst_n) begin
      m_on = 1'b1;
      m_tx_busy = 1'b0;
      m_txq.delete();
      m_fifo.delete();
      m_asm.delete();
      m_rxv = 1'b0;
      m_pkt = '0;
      m_ovf = 1'b0;
      m_nfull = 1'b0;
      m_txc = 0;
      m_rxc = 0;
      m_ovc = 0;
    end else if (m_on) begin
      if (m_tx_busy) begin
        if (!mesh_full) begin
          void'(m_txq.pop_front());
          if (m_txq.size() == 0) begin
            m_tx_busy = 1'b0;
            m_txc++;
          end
        end
      end else if (tx_valid) begin
        for (int i = PKT_FLITS - 1; i >= 0; i--) m_txq.push_back(tx_pkt[4*i +: 4]);
        m_tx_busy = 1'b1;
      end

      was_full = (m_fifo.size() == RX_DEPTH);
      do_pop = (m_fifo.size() > 0) && !((m_asm.size() == PKT_FLITS - 1) && m_rxv && !rx_ready);
      done = 1'b0;
      if (do_pop) begin
        f = m_fifo.pop_front();
        m_asm.push_back(f);
        if (m_asm.size() == PKT_FLITS) begin
          p = '0;
          foreach (m_asm[i]) p = (p << 4) | PW'(m_asm[i]);
          m_pkt = p;
          m_asm.delete();
          m_rxv = 1'b1;
          m_rxc++;
          done = 1'b1;
        end
      end
      if (!done && m_rxv && rx_ready) m_rxv = 1'b0;
      if (from_mesh_w) begin
        if (was_full) begin
          m_ovf = 1'b1;
          m_ovc++;
        end else begin
          m_fifo.push_back(from_mesh);
        end
      end
      m_nfull = (m_fifo.size() >= RX_DEPTH - 1);
    end
  end

  // Every-cycle comparison on the falling edge
  always @(negedge clk) begin
    if (m_on) begin
      check("to_mesh", to_mesh, m_tx_busy ? m_txq[0] : 4'h0);
      check("to_mesh_en", to_mesh_en, m_tx_busy && !mesh_full);
      check("tx_ready", tx_ready, !m_tx_busy);
      check("rx_valid", rx_valid, m_rxv);
      check("rx_pkt", rx_pkt, m_pkt);
      check("rx_ovf", rx_ovf, m_ovf);
      check("mesh_n_full", mesh_n_full, m_nfull);
`ifdef MESH_EDGE_STATS_EN
      check("tx_pkt_cnt", tx_pkt_cnt, (m_txc > 65535) ? 65535 : m_txc);
      check("rx_pkt_cnt", rx_pkt_cnt, (m_rxc > 65535) ? 65535 : m_rxc);
      check("ovf_cnt", ovf_cnt, (m_ovc > 65535) ? 65535 : m_ovc);
`endif
    end
  end

  initial begin
    rst_n = 1'b0; tx_valid = 1'b1; tx_pkt = 8'hFF; from_mesh_w = 1'b1; from_mesh = 4'h7;
    rx_ready = 1'b0; mesh_full = 1'b0;
    tick(); tick();
    check("rst_to_mesh_en", to_mesh_en, 1'b0);
    check("rst_to_mesh", to_mesh, 4'h0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_pkt", rx_pkt, 8'h00);
    check("rst_rx_ovf", rx_ovf, 1'b0);
    check("rst_n_full", mesh_n_full, 1'b0);
    rst_n = 1'b1; tx_valid = 1'b0; from_mesh_w = 1'b0;
    tick();
    check("rst_tx_ready", tx_ready, 1'b1);

    // Plain TX of 8'hA5
    tx_pkt = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("tx_flit0", to_mesh, 4'hA);
    check("tx_en0", to_mesh_en, 1'b1);
    check("tx_busy", tx_ready, 1'b0);
    tick();
    check("tx_flit1", to_mesh, 4'h5);
    check("tx_en1", to_mesh_en, 1'b1);
    tick();
    check("tx_idle", tx_ready, 1'b1);
    check("tx_idle_en", to_mesh_en, 1'b0);

    // TX with mesh_full during flit 1
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    mesh_full = 1'b1;
    #1;
    check("stall_en", to_mesh_en, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", to_mesh, 4'h5);
    end
    mesh_full = 1'b0;
    #1;
    check("stall_resume", to_mesh_en, 1'b1);
    tick();
    check("stall_done", tx_ready, 1'b1);

    // RX of 3,C with host ready
    rx_ready = 1'b1;
    from_mesh = 4'h3; from_mesh_w = 1'b1;
    tick();
    from_mesh = 4'hC;
    tick();
    from_mesh_w = 1'b0;
    tick();
    check("rx_valid_3c", rx_valid, 1'b1);
    check("rx_pkt_3c", rx_pkt, 8'h3C);
    tick();
    check("rx_valid_drop", rx_valid, 1'b0);

    // Backpressure: host stalled, 8 flits streamed
    rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      from_mesh = 4'(i + 1); from_mesh_w = 1'b1;
      tick();
      if (i == 4) check("bp_nfull_lo", mesh_n_full, 1'b0);
      if (i == 5) begin
        check("bp_nfull_hi", mesh_n_full, 1'b1);
        check("bp_pkt_12", rx_pkt, 8'h12);
      end
      if (i == 6) check("bp_no_ovf", rx_ovf, 1'b0);
      if (i == 7) begin
        check("bp_ovf", rx_ovf, 1'b1);
`ifdef MESH_EDGE_STATS_EN
        check("bp_ovf_cnt", ovf_cnt, 16'd1);
`endif
      end
    end
    from_mesh_w = 1'b0;
    repeat (3) tick();
    check("bp_hold_pkt", rx_pkt, 8'h12);
    check("bp_hold_valid", rx_valid, 1'b1);
    rx_ready = 1'b1;
    tick();
    check("bp_pkt_34", rx_pkt, 8'h34);
    check("bp_valid_34", rx_valid, 1'b1);
    tick(); tick();
    check("bp_pkt_56", rx_pkt, 8'h56);
    repeat (3) tick();
    check("bp_drained", mesh_n_full, 1'b0);

    // Reset in the middle of both a TX and an RX packet
    tx_pkt = 8'h96; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; from_mesh = 4'hE; from_mesh_w = 1'b1;
    tick();
    check("mid_tx_flit1", to_mesh, 4'h6);
    from_mesh_w = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_tx_ready", tx_ready, 1'b1);
    check("mid_rx_ovf_clr", rx_ovf, 1'b0);
    repeat (3) tick();
    check("mid_no_rx_valid", rx_valid, 1'b0);
    check("mid_no_tx", to_mesh_en, 1'b0);

    // Clean packets after the aborted ones
    from_mesh = 4'h2; from_mesh_w = 1'b1;
    tick();
    from_mesh = 4'h1;
    tick();
    from_mesh_w = 1'b0;
    tick();
    check("clean_rx_pkt", rx_pkt, 8'h21);
    check("clean_rx_valid", rx_valid, 1'b1);
    tx_pkt = 8'h3C; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("clean_tx0", to_mesh, 4'h3);
    tick();
    check("clean_tx1", to_mesh, 4'hC);
    tick();
    check("clean_tx_idle", tx_ready, 1'b1);
`ifdef MESH_EDGE_STATS_EN
    check("clean_tx_cnt", tx_pkt_cnt, 16'd1);
`endif
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
